// File: rtl/dm_bytelane_mem_pkg.sv
// Shared widths, sweep FSM encoding, trace record layout and byte-lane merge helper
// for the byte-lane data memory.
package dm_pkg;

    localparam int BYTEEN_W    = 4;
    localparam int WORD_W      = 32;
    localparam int TRACE_REC_W = 96;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dm_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] word;
    } trace_rec_t;

    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0]   old_word,
        input logic [WORD_W-1:0]   wdata,
        input logic [BYTEEN_W-1:0] byteen
    );
        logic [WORD_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BYTEEN_W; i++) begin
            if (byteen[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_bytelane_mem_if.sv
// M-stage data bus plus store-trace logger port of the byte-lane data memory.
interface dm_bytelane_mem_if
    import dm_pkg::*;
;
    logic [WORD_W-1:0]   m_data_addr;
    logic [WORD_W-1:0]   m_data_wdata;
    logic [BYTEEN_W-1:0] m_data_byteen;
    logic [WORD_W-1:0]   m_inst_addr;
    logic [WORD_W-1:0]   m_data_rdata;
    logic                mem_ready;
    logic                addr_err;
    logic                trace_valid;
    logic [WORD_W-1:0]   trace_pc;
    logic [WORD_W-1:0]   trace_addr;
    logic [WORD_W-1:0]   trace_word;
    logic                trace_ready;
    logic                trace_ovf;

    modport master (
        output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        input  m_data_rdata, mem_ready, addr_err, trace_valid, trace_pc, trace_addr,
               trace_word, trace_ovf
    );

    modport slave (
        input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        output m_data_rdata, mem_ready, addr_err, trace_valid, trace_pc, trace_addr,
               trace_word, trace_ovf
    );

endinterface

// File: rtl/dm_bytelane_mem_trace_fifo.sv
// Synchronous trace FIFO with sticky overflow flag.
// Latency: a pushed record becomes head one cycle later (no fall-through).
// Backpressure: push while full without a pop drops the record and sets ovf.
module dm_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 96
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat,
    input  logic         pop_rdy,
    output logic         ovf
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     ram [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    always_comb begin
        full    = (count == (PTR_W+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop_rdy && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push = push_vld && (!full || do_pop);
        drop    = push_vld && full && !do_pop;
        pop_vld = !empty;
        pop_dat = ram[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            ram[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_bytelane_mem.sv
// Byte-lane data memory: self-clearing sweep after reset, merged writes, store trace FIFO.
// Latency: writes commit at posedge; reads combinational (READ_LAT=0) or registered (READ_LAT=1).
// Backpressure: mem_ready low during the sweep; full trace FIFO drops records and sets trace_ovf.
module dm_bytelane_mem
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          READ_LAT    = 0,
    parameter int          TRACE_DEPTH = 8
) (
    input logic              clk,
    input logic              reset,
    dm_bytelane_mem_if.slave bus
);
    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    dm_state_e         state;
    logic [IDX_W-1:0]  sweep_idx;
    logic              mem_ready_q;
    logic              addr_err_q;

    logic [32:0]       offset;
    logic              in_range;
    logic              access;
    logic              wr_en;
    logic              err_now;
    logic [IDX_W-1:0]  acc_idx;
    logic [WORD_W-1:0] old_word;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] rd_word;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [WORD_W-1:0] mem_wdat;

    trace_rec_t        push_rec;
    trace_rec_t        head_rec;

    // 33-bit offset: an address below BASE_ADDR wraps above SPAN, so one compare covers both bounds.
    always_comb begin
        offset   = {1'b0, bus.m_data_addr} - {1'b0, BASE_ADDR};
        in_range = (offset < SPAN);
        acc_idx  = offset[IDX_W+1:2];
        old_word = mem[acc_idx];
        merged   = lane_merge(old_word, bus.m_data_wdata, bus.m_data_byteen);
        access   = (state == ST_READY) && (bus.m_data_byteen != '0);
        wr_en    = access && in_range;
        err_now  = access && !in_range;
        rd_word  = ((state == ST_READY) && in_range) ? old_word : '0;
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_widx = acc_idx;
        mem_wdat = merged;
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem_we   = 1'b1;
                mem_widx = sweep_idx;
                mem_wdat = '0;
            end else if (wr_en) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_CLEAR;
            sweep_idx   <= '0;
            mem_ready_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            addr_err_q <= err_now;
            if (state == ST_CLEAR) begin
                sweep_idx <= sweep_idx + IDX_W'(1);
                if (sweep_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                    state       <= ST_READY;
                    mem_ready_q <= 1'b1;
                end
            end
        end
    end

    generate
        if (READ_LAT == 0) begin : g_rd_comb
            assign bus.m_data_rdata = rd_word;
        end else begin : g_rd_reg
            logic [WORD_W-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rd_word;
                end
            end
            assign bus.m_data_rdata = rdata_q;
        end
    endgenerate

    always_comb begin
        push_rec.pc   = bus.m_inst_addr;
        push_rec.addr = {bus.m_data_addr[WORD_W-1:2], 2'b00};
        push_rec.word = merged;
    end

    dm_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .W     (TRACE_REC_W)
    ) u_trace_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (wr_en),
        .push_dat (push_rec),
        .pop_vld  (bus.trace_valid),
        .pop_dat  (head_rec),
        .pop_rdy  (bus.trace_ready),
        .ovf      (bus.trace_ovf)
    );

    assign bus.mem_ready  = mem_ready_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.trace_pc   = head_rec.pc;
    assign bus.trace_addr = head_rec.addr;
    assign bus.trace_word = head_rec.word;

endmodule
